// File: rtl/trap_ctrl.sv
// trap_ctrl: commit-stage trap/return controller (priv, status, xEPC/xCAUSE/xTVAL).
// Ports: commit_* / exc_* / irq CSR inputs in; priv, status_*, trap CSRs, busy, redirect_valid/pc out; redirect_ready in.
module trap_ctrl #(
  parameter int XLEN   = 64,
  parameter int NCAUSE = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              commit_valid,
  input  logic [XLEN-1:0]   commit_pc,
  input  logic              commit_mret,
  input  logic              commit_sret,
  input  logic [NCAUSE-1:0] exc_pending,
  input  logic [XLEN-1:0]   exc_tval,
  input  logic [NCAUSE-1:0] irq_pending,
  input  logic [NCAUSE-1:0] mie,
  input  logic [NCAUSE-1:0] mideleg,
  input  logic [NCAUSE-1:0] medeleg,
  input  logic [XLEN-1:0]   mtvec,
  input  logic [XLEN-1:0]   stvec,
  output logic [1:0]        priv,
  output logic              status_mie,
  output logic              status_mpie,
  output logic              status_sie,
  output logic              status_spie,
  output logic [1:0]        status_mpp,
  output logic              status_spp,
  output logic [XLEN-1:0]   mepc,
  output logic [XLEN-1:0]   sepc,
  output logic [XLEN-1:0]   mcause,
  output logic [XLEN-1:0]   scause,
  output logic [XLEN-1:0]   mtval,
  output logic [XLEN-1:0]   stval,
  output logic              busy,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc,
  input  logic              redirect_ready
);

  localparam int CW = $clog2(NCAUSE);
  localparam logic [1:0] PRV_M = 2'b11;
  localparam logic [1:0] PRV_S = 2'b01;
  localparam logic [1:0] PRV_U = 2'b00;

  typedef enum logic {IDLE, REDIRECT} state_e;

  // Ascending scan leaves the highest set bit; fixed
  // priorities are then applied lowest-first so 11 wins.
  function automatic logic [CW-1:0] irq_pick(
    input logic [NCAUSE-1:0] v);
    logic [CW-1:0] r;
    r = '0;
    for (int i = 0; i < NCAUSE; i++)
      if (v[i]) r = CW'(i);
    if (v[5])  r = CW'(5);
    if (v[1])  r = CW'(1);
    if (v[9])  r = CW'(9);
    if (v[7])  r = CW'(7);
    if (v[3])  r = CW'(3);
    if (v[11]) r = CW'(11);
    return r;
  endfunction

  // Descending scan leaves the lowest set bit; the
  // fixed list is applied in reverse so cause 3 wins.
  function automatic logic [CW-1:0] exc_pick(
    input logic [NCAUSE-1:0] v);
    logic [CW-1:0] r;
    r = '0;
    for (int i = NCAUSE - 1; i >= 0; i--)
      if (v[i]) r = CW'(i);
    if (v[5])  r = CW'(5);
    if (v[7])  r = CW'(7);
    if (v[13]) r = CW'(13);
    if (v[15]) r = CW'(15);
    if (v[4])  r = CW'(4);
    if (v[6])  r = CW'(6);
    if (v[11]) r = CW'(11);
    if (v[9])  r = CW'(9);
    if (v[8])  r = CW'(8);
    if (v[0])  r = CW'(0);
    if (v[2])  r = CW'(2);
    if (v[1])  r = CW'(1);
    if (v[12]) r = CW'(12);
    if (v[3])  r = CW'(3);
    return r;
  endfunction

  state_e          state_q;
  logic [1:0]      priv_q;
  logic            mie_q, mpie_q, sie_q, spie_q;
  logic [1:0]      mpp_q;
  logic            spp_q;
  logic [XLEN-1:0] mepc_q, sepc_q;
  logic [XLEN-1:0] mcause_q, scause_q;
  logic [XLEN-1:0] mtval_q, stval_q;
  logic [XLEN-1:0] rpc_q;
  logic            rvalid_q;

  logic [NCAUSE-1:0] en, m_take, s_take;
  logic            irq_any, exc_any, ill_ret;
  logic            trap, to_s, do_mret, do_sret, fire;
  logic [CW-1:0]   cause;
  logic [XLEN-1:0] tval_d, cause_d, tvec, base, tgt_d;

  always_comb begin
    en      = irq_pending & mie;
    m_take  = '0;
    s_take  = '0;
    if (priv_q != PRV_M || mie_q)
      m_take = en & ~mideleg;
    if (priv_q == PRV_U || (priv_q == PRV_S && sie_q))
      s_take = en & mideleg;
    irq_any = |m_take || |s_take;
    exc_any = |exc_pending;
    ill_ret = (commit_mret && priv_q != PRV_M) ||
              (commit_sret && priv_q == PRV_U);
    trap    = irq_any || exc_any || ill_ret;
    do_mret = !trap && commit_mret;
    do_sret = !trap && !commit_mret && commit_sret;
    fire    = state_q == IDLE && commit_valid &&
              (trap || do_mret || do_sret);

    cause  = CW'(2);
    tval_d = '0;
    to_s   = 1'b0;
    if (irq_any) begin
      // A taken M-level interrupt masks every S candidate.
      cause = irq_pick(|m_take ? m_take : s_take);
      to_s  = ~|m_take;
    end else begin
      if (exc_any) begin
        cause  = exc_pick(exc_pending);
        tval_d = exc_tval;
      end
      to_s = priv_q != PRV_M && medeleg[cause];
    end

    cause_d = XLEN'(cause);
    cause_d[XLEN-1] = irq_any;
    tvec = to_s ? stvec : mtvec;
    base = {tvec[XLEN-1:2], 2'b00};
    tgt_d = base;
    if (tvec[1:0] == 2'b01 && irq_any)
      tgt_d = base + (XLEN'(cause) << 2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      priv_q   <= PRV_M;
      mie_q    <= 1'b0;
      mpie_q   <= 1'b0;
      sie_q    <= 1'b0;
      spie_q   <= 1'b0;
      mpp_q    <= PRV_U;
      spp_q    <= 1'b0;
      mepc_q   <= '0;
      sepc_q   <= '0;
      mcause_q <= '0;
      scause_q <= '0;
      mtval_q  <= '0;
      stval_q  <= '0;
      rpc_q    <= '0;
      rvalid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fire) begin
            state_q  <= REDIRECT;
            rvalid_q <= 1'b1;
            if (trap) begin
              rpc_q <= tgt_d;
              if (to_s) begin
                sepc_q   <= commit_pc;
                scause_q <= cause_d;
                stval_q  <= tval_d;
                spie_q   <= sie_q;
                sie_q    <= 1'b0;
                spp_q    <= priv_q[0];
                priv_q   <= PRV_S;
              end else begin
                mepc_q   <= commit_pc;
                mcause_q <= cause_d;
                mtval_q  <= tval_d;
                mpie_q   <= mie_q;
                mie_q    <= 1'b0;
                mpp_q    <= priv_q;
                priv_q   <= PRV_M;
              end
            end else if (do_mret) begin
              rpc_q  <= mepc_q;
              priv_q <= mpp_q;
              mie_q  <= mpie_q;
              mpie_q <= 1'b1;
              mpp_q  <= PRV_U;
            end else begin
              rpc_q  <= sepc_q;
              priv_q <= {1'b0, spp_q};
              sie_q  <= spie_q;
              spie_q <= 1'b1;
              spp_q  <= 1'b0;
            end
          end
        end
        REDIRECT: begin
          if (rvalid_q && redirect_ready) begin
            state_q  <= IDLE;
            rvalid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign priv           = priv_q;
  assign status_mie     = mie_q;
  assign status_mpie    = mpie_q;
  assign status_sie     = sie_q;
  assign status_spie    = spie_q;
  assign status_mpp     = mpp_q;
  assign status_spp     = spp_q;
  assign mepc           = mepc_q;
  assign sepc           = sepc_q;
  assign mcause         = mcause_q;
  assign scause         = scause_q;
  assign mtval          = mtval_q;
  assign stval          = stval_q;
  assign busy           = rvalid_q;
  assign redirect_valid = rvalid_q;
  assign redirect_pc    = rpc_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed-vector bench for trap_ctrl.
// Walks priv M->U->S->M through traps and xRETs, checks CSRs and redirect.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        commit_valid;
  logic [63:0] commit_pc;
  logic        commit_mret, commit_sret;
  logic [15:0] exc_pending;
  logic [63:0] exc_tval;
  logic [15:0] irq_pending, mie, mideleg, medeleg;
  logic [63:0] mtvec, stvec;
  logic [1:0]  priv;
  logic        status_mie, status_mpie, status_sie, status_spie;
  logic [1:0]  status_mpp;
  logic        status_spp;
  logic [63:0] mepc, sepc, mcause, scause, mtval, stval;
  logic        busy, redirect_valid, redirect_ready;
  logic [63:0] redirect_pc;

  int n_cmp = 0;
  int n_bad = 0;

  trap_ctrl #(.XLEN(64), .NCAUSE(16)) dut (
    .clk(clk), .rst(rst),
    .commit_valid(commit_valid), .commit_pc(commit_pc),
    .commit_mret(commit_mret), .commit_sret(commit_sret),
    .exc_pending(exc_pending), .exc_tval(exc_tval),
    .irq_pending(irq_pending), .mie(mie),
    .mideleg(mideleg), .medeleg(medeleg),
    .mtvec(mtvec), .stvec(stvec),
    .priv(priv),
    .status_mie(status_mie), .status_mpie(status_mpie),
    .status_sie(status_sie), .status_spie(status_spie),
    .status_mpp(status_mpp), .status_spp(status_spp),
    .mepc(mepc), .sepc(sepc),
    .mcause(mcause), .scause(scause),
    .mtval(mtval), .stval(stval),
    .busy(busy),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fire();
    commit_valid = 1'b1;
    tick();
    commit_valid = 1'b0;
    commit_mret  = 1'b0;
    commit_sret  = 1'b0;
    exc_pending  = '0;
    irq_pending  = '0;
  endtask

  task automatic ack(input string tag);
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    chk({tag, "_drop"}, 64'(redirect_valid), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    commit_valid = 0; commit_pc = '0;
    commit_mret = 0; commit_sret = 0;
    exc_pending = '0; exc_tval = '0;
    irq_pending = '0; mie = '0;
    mideleg = '0; medeleg = '0;
    mtvec = '0; stvec = '0;
    redirect_ready = 0;
    tick(); tick();
    rst = 1'b0;

    chk("rst_priv", 64'(priv), 64'd3);
    chk("rst_rv", 64'(redirect_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mepc", mepc, 64'd0);
    chk("rst_mpp", 64'(status_mpp), 64'd0);

    // ecall from M, vectored mtvec but exception -> base
    commit_pc = 64'h100; exc_tval = 64'h55;
    exc_pending = 16'h0800;
    mtvec = 64'h8000_0001;
    fire();
    chk("ec_rv", 64'(redirect_valid), 64'd1);
    chk("ec_busy", 64'(busy), 64'd1);
    chk("ec_pc", redirect_pc, 64'h8000_0000);
    chk("ec_mcause", mcause, 64'd11);
    chk("ec_mepc", mepc, 64'h100);
    chk("ec_mtval", mtval, 64'h55);
    chk("ec_mie", 64'(status_mie), 64'd0);
    chk("ec_mpp", 64'(status_mpp), 64'd3);
    for (int i = 0; i < 3; i++) begin
      commit_valid = 1'b1;
      exc_pending = 16'h0001;
      tick();
      chk("hold_rv", 64'(redirect_valid), 64'd1);
      chk("hold_pc", redirect_pc, 64'h8000_0000);
    end
    commit_valid = 0; exc_pending = '0;
    chk("hold_mepc", mepc, 64'h100);
    ack("ec");

    // MRET x2: first restores M with mpp->00, second drops to U
    commit_mret = 1'b1;
    fire();
    chk("mr1_pc", redirect_pc, 64'h100);
    chk("mr1_priv", 64'(priv), 64'd3);
    chk("mr1_mpie", 64'(status_mpie), 64'd1);
    ack("mr1");
    commit_mret = 1'b1;
    fire();
    chk("mr2_priv", 64'(priv), 64'd0);
    chk("mr2_mie", 64'(status_mie), 64'd1);
    ack("mr2");

    // U: delegated interrupts 1,5,9 -> S cause 9 vectored
    commit_pc = 64'h200;
    irq_pending = 16'h0222; mie = 16'h0222;
    mideleg = 16'h0222; stvec = 64'h1001;
    fire();
    chk("si_scause", scause, 64'h8000_0000_0000_0009);
    chk("si_pc", redirect_pc, 64'h1024);
    chk("si_spp", 64'(status_spp), 64'd0);
    chk("si_priv", 64'(priv), 64'd1);
    chk("si_sepc", sepc, 64'h200);
    chk("si_stval", stval, 64'd0);
    ack("si");

    // S, sie=0: bit7 delegated and masked, bit11 to M
    commit_pc = 64'h300;
    irq_pending = 16'h0880; mie = 16'h0880;
    mideleg = 16'h0080;
    fire();
    chk("mi_mcause", mcause, 64'h8000_0000_0000_000b);
    chk("mi_pc", redirect_pc, 64'h8000_002c);
    chk("mi_priv", 64'(priv), 64'd3);
    chk("mi_mpp", 64'(status_mpp), 64'd1);
    chk("mi_mpie", 64'(status_mpie), 64'd1);
    chk("mi_mtval", mtval, 64'd0);
    ack("mi");

    // MRET M->S
    commit_mret = 1'b1;
    fire();
    chk("mr3_priv", 64'(priv), 64'd1);
    chk("mr3_mie", 64'(status_mie), 64'd1);
    chk("mr3_mpp", 64'(status_mpp), 64'd0);
    chk("mr3_pc", redirect_pc, 64'h300);
    ack("mr3");

    // interrupt beats exception
    commit_pc = 64'h400; exc_tval = 64'hdead;
    exc_pending = 16'h0005;
    irq_pending = 16'h0008; mie = 16'h0008;
    mideleg = '0; mtvec = 64'h4000;
    fire();
    chk("ie_mcause", mcause, 64'h8000_0000_0000_0003);
    chk("ie_pc", redirect_pc, 64'h4000);
    chk("ie_mtval", mtval, 64'd0);
    ack("ie");
    commit_mret = 1'b1;
    fire();
    chk("mr4_priv", 64'(priv), 64'd1);
    ack("mr4");

    // no interrupt: cause 2 beats cause 0
    commit_pc = 64'h500;
    exc_pending = 16'h0005;
    fire();
    chk("ex_mcause", mcause, 64'd2);
    chk("ex_mtval", mtval, 64'hdead);
    chk("ex_mepc", mepc, 64'h500);
    chk("ex_priv", 64'(priv), 64'd3);
    ack("ex");

    // M->S via MRET, then SRET S->U
    commit_mret = 1'b1;
    fire();
    ack("mr5");
    commit_sret = 1'b1;
    fire();
    chk("sr_priv", 64'(priv), 64'd0);
    chk("sr_pc", redirect_pc, 64'h200);
    chk("sr_spie", 64'(status_spie), 64'd1);
    ack("sr");

    // SRET from U is illegal -> cause 2, tval 0
    commit_pc = 64'h600;
    commit_sret = 1'b1;
    fire();
    chk("il_mcause", mcause, 64'd2);
    chk("il_mtval", mtval, 64'd0);
    chk("il_priv", 64'(priv), 64'd3);
    chk("il_mpp", 64'(status_mpp), 64'd0);
    ack("il");

    // commit_valid low: nothing happens
    exc_pending = 16'h0800;
    tick();
    chk("nv_rv", 64'(redirect_valid), 64'd0);
    chk("nv_mepc", mepc, 64'h600);

    // reset in REDIRECT
    commit_pc = 64'h700;
    fire();
    chk("rr_rv", 64'(redirect_valid), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rr_rv0", 64'(redirect_valid), 64'd0);
    chk("rr_priv", 64'(priv), 64'd3);
    chk("rr_mepc", mepc, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Sequential trap/return controller. It is the successor to the combinational trap-select logic and is parametrised in XLEN and cause-vector width.
- Sits at the commit stage. Samples pending interrupts and exceptions on each committed instruction, then selects cause and target mode using architecturally correct priority.
- Owns the priv register, the trap-related status bits and the xEPC/xCAUSE/xTVAL registers. Executes MRET/SRET.
- Issues a held redirect/flush handshake to the fetch stage.

Parameters:
- XLEN, 64, data/address width of pc, tvec, epc, tval, cause.
- NCAUSE, 16, width of the cause, pending, enable and delegation vectors; must be in the range 16..XLEN-1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- commit_valid  in  1  an instruction retires or faults this cycle
- commit_pc  in  XLEN  pc of that instruction
- commit_mret  in  1  retiring instruction is MRET
- commit_sret  in  1  retiring instruction is SRET
- exc_pending  in  NCAUSE  exception bits raised by that instruction
- exc_tval  in  XLEN  trap value for the exception
- irq_pending  in  NCAUSE  mip
- mie  in  NCAUSE  interrupt enable
- mideleg  in  NCAUSE  interrupt delegation
- medeleg  in  NCAUSE  exception delegation
- mtvec  in  XLEN  M trap vector
- stvec  in  XLEN  S trap vector
- priv  out  2  current privilege: 11=M, 01=S, 00=U
- status_mie, status_mpie, status_sie, status_spie  out  1 each  status bits
- status_mpp  out  2  M previous privilege
- status_spp  out  1  S previous privilege
- mepc, sepc, mcause, scause, mtval, stval  out  XLEN each  trap CSRs
- busy  out  1  high while in REDIRECT; the pipeline stalls commit
- redirect_valid  out  1  redirect request
- redirect_pc  out  XLEN  target pc
- redirect_ready  in  1  fetch accepts the redirect

Behaviour:
- Reset: priv=11; all status bits 0; mpp=00; all epc/cause/tval registers 0; redirect_valid=0; busy=0; state IDLE. A reset asserted in REDIRECT drops the request on the next edge.
- FSM states: IDLE and REDIRECT.
- IDLE → REDIRECT: when commit_valid=1 and an event is selected. All register updates happen on that same edge. redirect_valid=1 and busy=1 from the next cycle; 1-cycle latency.
- REDIRECT: redirect_valid and redirect_pc held stable until redirect_valid&&redirect_ready, then return to IDLE. commit_valid is ignored in REDIRECT.
- Interrupt selection, taken only on a commit_valid cycle:
  - en = irq_pending & mie.
  - M-candidates = en & ~mideleg; taken if priv!=M or status_mie.
  - S-candidates = en & mideleg; taken if priv==U, or priv==S and status_sie; never taken in M.
  - Any taken M-candidate wins over S-candidates.
  - Priority within a set: 11, 3, 7, 9, 1, 5, then remaining bits from the highest index down.
- Exception selection:
  - Priority order: 3, 12, 1, 2, 0, 8, 9, 11, 6, 4, 15, 13, 7, 5, then remaining bits ascending.
  - Target is S iff priv!=M and medeleg[cause]; otherwise M.
- Illegal xRET: MRET with priv!=M, or SRET with priv==U, is converted to exception cause 2 with tval=0 and goes through normal delegation.
- Event precedence: interrupt > exception > xRET.
- Trap to M:
  - mepc=commit_pc; mcause={irq,0…,cause}.
  - mtval=exc_tval for an exception, 0 for an interrupt.
  - mpie=mie; mie=0; mpp=priv; priv=M.
- Trap to S:
  - Same updates on sepc/scause/stval.
  - spie=sie; sie=0; spp=priv[0]; priv=S.
- Trap target pc:
  - Base is xtvec with bits [1:0] cleared.
  - If xtvec[1:0]==01 and the trap is an interrupt: target = base + 4·cause (XLEN-bit wraparound).
  - Otherwise: target = base.
- MRET: priv=mpp; mie=mpie; mpie=1; mpp=00; redirect_pc=mepc (pre-update value).
- SRET: priv={0,spp}; sie=spie; spie=1; spp=0; redirect_pc=sepc.
- commit_valid=0: no state change, regardless of pending bits.
- No event selected: no state change; the FSM stays in IDLE.

Test Plan:
- Reset, then commit_valid with exc_pending=0x0800 (ecall-M), mtvec=0x8000_0001 → next cycle redirect_valid=1, redirect_pc=0x8000_0000, mcause=11, mepc=commit_pc, mie=0, mpp=11; redirect held across 3 cycles of redirect_ready=0.
- priv=U; irq_pending=0x0222, mie=0x0222, mideleg=0x0222, stvec=0x1001 → S trap, scause=(1<<63)|9, redirect_pc=0x1000+36, spp=0, priv=01.
- priv=S, sie=0, irq_pending=mie=0x0880, mideleg=0x0080 → M trap with cause 11 (bit 7 is delegated and masked since sie=0); priv=11.
- Same commit with exc_pending=0x0005 and an enabled M interrupt → interrupt taken. Without the interrupt → exception cause 2 (priority over cause 0), mtval=exc_tval.
- SRET with priv=U → illegal trap cause 2. MRET from M with mpp=01, mpie=1 → priv=01, mie=1, mpp=00, redirect_pc=mepc.
- rst asserted mid-REDIRECT → next cycle redirect_valid=0, priv=11, mepc=0.
